max7219_scheduler: RTL

- Sequences all traffic from the stopwatch to the existing 16-bit SPI master that drives the MAX7219 display driver.
- Arbitrates between three sources: the power-up init burst, single config writes from the user, and 6-digit frame refreshes triggered by the 100 Hz divided clock.
- Sits between the counter chain / controller and the SPI master, and replaces the ad-hoc sequencing FSM in the current display wrapper.

---
 rtl/max7219_pkg.sv | 44 ++++
 rtl/max7219_scheduler_if.sv | 23 ++
 rtl/max7219_word_rom.sv | 51 +++++
 rtl/max7219_scheduler.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/max7219_pkg.sv
// Shared types and constants for the MAX7219 display traffic scheduler.
package max7219_pkg;

  localparam int unsigned WORD_W    = 16;
  localparam int unsigned DIGITS_W  = 24;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned INIT_LEN  = 5;
  localparam int unsigned CFG_LEN   = 1;
  localparam int unsigned FRAME_LEN = 6;

  // MAX7219 register addresses
  localparam logic [3:0] DIGIT0    = 4'h1;
  localparam logic [3:0] DIGIT1    = 4'h2;
  localparam logic [3:0] DIGIT2    = 4'h3;
  localparam logic [3:0] DIGIT3    = 4'h4;
  localparam logic [3:0] DIGIT4    = 4'h5;
  localparam logic [3:0] DIGIT5    = 4'h6;
  localparam logic [3:0] DECODE    = 4'h9;
  localparam logic [3:0] INTENSITY = 4'hA;
  localparam logic [3:0] SCAN      = 4'hB;
  localparam logic [3:0] SHUTDOWN  = 4'hC;
  localparam logic [3:0] TEST      = 4'hF;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT_SENT, ST_RELEASE} state_e;
  typedef enum logic [1:0] {SRC_INIT, SRC_CFG, SRC_FRAME} src_e;

  // One 16-bit MAX7219 command word
  typedef struct packed {
    logic [3:0] pad;
    logic [3:0] addr;
    logic [7:0] data;
  } word_t;

  // Number of words a burst of the given source carries
  function automatic logic [IDX_W-1:0] burst_len(src_e src);
    case (src)
      SRC_INIT:  burst_len = IDX_W'(INIT_LEN);
      SRC_CFG:   burst_len = IDX_W'(CFG_LEN);
      SRC_FRAME: burst_len = IDX_W'(FRAME_LEN);
      default:   burst_len = IDX_W'(CFG_LEN);
    endcase
  endfunction

endpackage

// File: rtl/max7219_scheduler_if.sv
// Config-write and SPI-master handshake bundle for the scheduler.
interface max7219_scheduler_if;
  import max7219_pkg::*;

  logic              cfg_valid;
  logic [3:0]        cfg_addr;
  logic [7:0]        cfg_data;
  logic              cfg_ready;
  logic              spi_ready;
  logic              spi_sent;
  logic [WORD_W-1:0] word_out;
  logic              cs_n;

  modport master (
    input  cfg_valid, cfg_addr, cfg_data, spi_ready, spi_sent,
    output cfg_ready, word_out, cs_n
  );

  modport slave (
    output cfg_valid, cfg_addr, cfg_data, spi_ready, spi_sent,
    input  cfg_ready, word_out, cs_n
  );
endinterface

// File: rtl/max7219_word_rom.sv
// Maps (burst source, word index, digit snapshot, config word) to the outgoing word.
module max7219_word_rom
  import max7219_pkg::*;
#(
  parameter logic [3:0] INTENSITY_DEFAULT = 4'h8,
  parameter logic [2:0] SCAN_LIMIT        = 3'd5
) (
  input  src_e                src_i,
  input  logic [IDX_W-1:0]    index_i,
  input  logic [DIGITS_W-1:0] snap_i,
  input  logic [WORD_W-1:0]   cfg_word_i,
  output logic [WORD_W-1:0]   word_o
);

  logic [3:0] nib;
  logic       dp;

  // Word selection; tens digits of sec/min drop their pad bit
  always_comb begin
    word_o = '0;
    nib    = '0;
    dp     = 1'b0;
    case (src_i)
      SRC_INIT: begin
        case (index_i)
          3'd0:    word_o = {4'h0, SHUTDOWN, 8'h01};
          3'd1:    word_o = {4'h0, DECODE, 8'hFF};
          3'd2:    word_o = {4'h0, SCAN, 5'h00, SCAN_LIMIT};
          3'd3:    word_o = {4'h0, INTENSITY, 4'h0, INTENSITY_DEFAULT};
          3'd4:    word_o = {4'h0, TEST, 8'h00};
          default: word_o = '0;
        endcase
      end
      SRC_CFG: word_o = cfg_word_i;
      SRC_FRAME: begin
        case (index_i)
          3'd0:    nib = snap_i[3:0];
          3'd1:    nib = snap_i[7:4];
          3'd2:    begin nib = snap_i[11:8];  dp = 1'b1; end
          3'd3:    nib = {1'b0, snap_i[14:12]};
          3'd4:    begin nib = snap_i[19:16]; dp = 1'b1; end
          3'd5:    nib = {1'b0, snap_i[22:20]};
          default: nib = '0;
        endcase
        word_o = {4'h0, DIGIT0 + 4'(index_i), dp, 3'b000, nib};
      end
      default: word_o = '0;
    endcase
  end

endmodule

// File: rtl/max7219_scheduler.sv
// Arbitrates init, config and frame bursts onto the 16-bit MAX7219 SPI master.
module max7219_scheduler
  import max7219_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES    = 256,
  parameter logic [3:0]  INTENSITY_DEFAULT = 4'h8,
  parameter logic [2:0]  SCAN_LIMIT        = 3'd5
) (
  input  logic                clk,
  input  logic                res,
  input  logic                tick,
  input  logic                ena,
  input  logic [DIGITS_W-1:0] digits,
  max7219_scheduler_if.master bus,
  output logic                busy,
  output logic                init_done,
  output logic                frame_done,
  output logic                overrun,
  output logic                timeout_err
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = '1;

  state_e              state_q, state_d;
  src_e                src_q, src_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                tick_q, tick_d;
  logic                init_pending_q, init_pending_d;
  logic                cfg_pending_q, cfg_pending_d;
  logic                frame_pending_q, frame_pending_d;
  word_t               cfg_word_q, cfg_word_d;
  logic [DIGITS_W-1:0] snap_q, snap_d;
  logic [WORD_W-1:0]   word_out_q, word_out_d;
  logic                cs_n_q, cs_n_d;
  logic                busy_q, busy_d;
  logic                init_done_q, init_done_d;
  logic                frame_done_q, frame_done_d;
  logic                overrun_q, overrun_d;
  logic                timeout_err_q, timeout_err_d;
  logic [WORD_W-1:0]   rom_word_c;
  logic                tick_edge_c;

  assign tick_edge_c = tick & ~tick_q;

  max7219_word_rom #(
    .INTENSITY_DEFAULT (INTENSITY_DEFAULT),
    .SCAN_LIMIT        (SCAN_LIMIT)
  ) u_rom (
    .src_i      (src_q),
    .index_i    (idx_q),
    .snap_i     (snap_q),
    .cfg_word_i (cfg_word_q),
    .word_o     (rom_word_c)
  );

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (res) begin
      state_q         <= ST_IDLE;
      src_q           <= SRC_INIT;
      idx_q           <= '0;
      tmo_q           <= '0;
      tick_q          <= 1'b0;
      init_pending_q  <= 1'b1;
      cfg_pending_q   <= 1'b0;
      frame_pending_q <= 1'b0;
      cfg_word_q      <= '0;
      snap_q          <= '0;
      word_out_q      <= '0;
      cs_n_q          <= 1'b1;
      busy_q          <= 1'b0;
      init_done_q     <= 1'b0;
      frame_done_q    <= 1'b0;
      overrun_q       <= 1'b0;
      timeout_err_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      src_q           <= src_d;
      idx_q           <= idx_d;
      tmo_q           <= tmo_d;
      tick_q          <= tick_d;
      init_pending_q  <= init_pending_d;
      cfg_pending_q   <= cfg_pending_d;
      frame_pending_q <= frame_pending_d;
      cfg_word_q      <= cfg_word_d;
      snap_q          <= snap_d;
      word_out_q      <= word_out_d;
      cs_n_q          <= cs_n_d;
      busy_q          <= busy_d;
      init_done_q     <= init_done_d;
      frame_done_q    <= frame_done_d;
      overrun_q       <= overrun_d;
      timeout_err_q   <= timeout_err_d;
    end
  end

  // Request capture, burst arbitration and word handshake sequencing
  always_comb begin
    state_d         = state_q;
    src_d           = src_q;
    idx_d           = idx_q;
    tmo_d           = tmo_q;
    tick_d          = tick;
    init_pending_d  = init_pending_q;
    cfg_pending_d   = cfg_pending_q;
    frame_pending_d = frame_pending_q;
    cfg_word_d      = cfg_word_q;
    snap_d          = snap_q;
    word_out_d      = word_out_q;
    cs_n_d          = cs_n_q;
    busy_d          = busy_q;
    init_done_d     = init_done_q;
    frame_done_d    = 1'b0;
    overrun_d       = 1'b0;
    timeout_err_d   = timeout_err_q;

    if (bus.cfg_valid && !cfg_pending_q) begin
      cfg_pending_d = 1'b1;
      cfg_word_d    = '{pad: 4'h0, addr: bus.cfg_addr, data: bus.cfg_data};
    end

    case (state_q)
      ST_IDLE: begin
        if (init_pending_q || cfg_pending_q || frame_pending_q) begin
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_ISSUE;
          if (init_pending_q) begin
            src_d = SRC_INIT;
          end else if (cfg_pending_q) begin
            src_d         = SRC_CFG;
            cfg_pending_d = 1'b0;
          end else begin
            src_d           = SRC_FRAME;
            frame_pending_d = 1'b0;
            snap_d          = digits;
          end
        end
      end
      ST_ISSUE: begin
        if (bus.spi_ready && !bus.spi_sent) begin
          word_out_d = rom_word_c;
          cs_n_d     = 1'b0;
          tmo_d      = '0;
          state_d    = ST_WAIT_SENT;
        end
      end
      ST_WAIT_SENT: begin
        if (bus.spi_sent) begin
          cs_n_d  = 1'b1;
          idx_d   = idx_q + IDX_W'(1);
          state_d = ST_RELEASE;
        end else if (tmo_q >= TMO_LAST) begin
          // Abort: an init burst keeps init_pending and restarts from word 0
          cs_n_d        = 1'b1;
          timeout_err_d = 1'b1;
          busy_d        = 1'b0;
          state_d       = ST_IDLE;
        end else if (tmo_q != TMO_MAX) begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_RELEASE: begin
        if (idx_q < burst_len(src_q)) begin
          state_d = ST_ISSUE;
        end else begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
          if (src_q == SRC_INIT) begin
            init_done_d    = 1'b1;
            init_pending_d = 1'b0;
          end else if (src_q == SRC_FRAME) begin
            frame_done_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Evaluated after a possible burst-start clear so a frame in flight can queue one more
    if (tick_edge_c && ena) begin
      if (frame_pending_d) overrun_d = 1'b1;
      else                 frame_pending_d = 1'b1;
    end
  end

  assign bus.cfg_ready = ~cfg_pending_q;
  assign bus.word_out  = word_out_q;
  assign bus.cs_n      = cs_n_q;
  assign busy          = busy_q;
  assign init_done     = init_done_q;
  assign frame_done    = frame_done_q;
  assign overrun       = overrun_q;
  assign timeout_err   = timeout_err_q;

endmodule
